// File: rtl/mux4_1_conditional_data_pkg.sv
// Shared constants and types for the 4:1 conditional-data mux.
// Select codes are the concatenation {sela, selc}.
package mux4_pkg;

    localparam int MUX4_DEF_WIDTH = 1;

    typedef logic [1:0] mux4_sel_t;

    localparam mux4_sel_t SEL_D0 = 2'b00;
    localparam mux4_sel_t SEL_D1 = 2'b01;
    localparam mux4_sel_t SEL_D2 = 2'b10;
    localparam mux4_sel_t SEL_D3 = 2'b11;

    // Packs the two loose select pins into one select code.
    function automatic mux4_sel_t mux4_sel(input logic sela, input logic selc);
        return {sela, selc};
    endfunction

endpackage

// File: rtl/mux4_1_conditional_data_if.sv
// Bus bundle for mux4_1_conditional_data: data, selects, load enable and outputs.
// zout_comb is present only when MUX4_COMB_OUT_EN is defined.
interface mux4_1_conditional_data_if #(
    parameter int WIDTH = mux4_pkg::MUX4_DEF_WIDTH
);

    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic             sela;
    logic             selc;
    logic             en;
    logic [WIDTH-1:0] zout;
`ifdef MUX4_COMB_OUT_EN
    logic [WIDTH-1:0] zout_comb;

    modport master (
        output d0, d1, d2, d3, sela, selc, en,
        input  zout, zout_comb
    );

    modport slave (
        input  d0, d1, d2, d3, sela, selc, en,
        output zout, zout_comb
    );
`else
    modport master (
        output d0, d1, d2, d3, sela, selc, en,
        input  zout
    );

    modport slave (
        input  d0, d1, d2, d3, sela, selc, en,
        output zout
    );
`endif

endinterface

// File: rtl/mux4_1_conditional_data_sel_comb.sv
// Pure combinational 4:1 selector built from nested conditionals.
// An X on a select bit is allowed to propagate to sel_d.
module mux4_1_sel_comb
    import mux4_pkg::*;
#(
    parameter int WIDTH = MUX4_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  mux4_sel_t        sel,
    output logic [WIDTH-1:0] sel_d
);

    assign sel_d = sel[1] ? (sel[0] ? d3 : d2)
                          : (sel[0] ? d1 : d0);

endmodule

// File: rtl/mux4_1_conditional_data.sv
// 4:1 data mux with an enable-qualified, async-reset output register.
// Define MUX4_COMB_OUT_EN to also expose the unregistered selection as zout_comb.
module mux4_1_conditional_data
    import mux4_pkg::*;
#(
    parameter int WIDTH = MUX4_DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    mux4_1_conditional_data_if.slave   bus
);

    mux4_sel_t        sel;
    logic [WIDTH-1:0] sel_d;
    logic [WIDTH-1:0] zout_q;

    assign sel = mux4_sel(bus.sela, bus.selc);

    mux4_1_sel_comb #(
        .WIDTH (WIDTH)
    ) u_sel (
        .d0    (bus.d0),
        .d1    (bus.d1),
        .d2    (bus.d2),
        .d3    (bus.d3),
        .sel   (sel),
        .sel_d (sel_d)
    );

    // Reset wins over en; nothing captured before reset is replayed afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zout_q <= '0;
        end else if (bus.en) begin
            zout_q <= sel_d;
        end
    end

    assign bus.zout = zout_q;

`ifdef MUX4_COMB_OUT_EN
    assign bus.zout_comb = sel_d;
`endif

endmodule

// File: tb/tb_mux4_1_conditional_data.sv
// Directed plus randomized checks of mux4_1_conditional_data against an array-indexed reference.
// Comb-output checks are active when MUX4_COMB_OUT_EN is defined.
module tb_mux4_1_conditional_data;
    import mux4_pkg::*;

    localparam int W = 1;

    logic clk = 1'b0;
    logic rst;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] dv [4];
    mux4_sel_t    sv;
    logic         env;
    logic [W-1:0] exp_z;

    mux4_1_conditional_data_if #(.WIDTH(W)) bus ();

    mux4_1_conditional_data #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    // Reference: the selected input is simply the data array indexed by the select code.
    function automatic logic [W-1:0] ref_sel();
        return dv[sv];
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] e,
                         input mux4_sel_t s, input logic en_i);
        dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = e;
        sv  = s;
        env = en_i;
        bus.d0 = a; bus.d1 = b; bus.d2 = c; bus.d3 = e;
        bus.sela = s[1];
        bus.selc = s[0];
        bus.en   = en_i;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_comb(input string tag);
`ifdef MUX4_COMB_OUT_EN
        #1;
        chk(tag, bus.zout_comb, ref_sel());
`else
        #0;
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    // One clock: the model register follows the same rule as the spec, then sample 1 unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) exp_z = '0;
        else if (env) exp_z = ref_sel();
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        rst = 1'b1;
        exp_z = '0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, SEL_D0, 1'b1);
        #1;
        chk("rst_async_no_edge", bus.zout, 1'b0);
        chk_comb("comb_during_rst");
        tick();
        chk("rst_hold_edge1", bus.zout, 1'b0);
        tick();
        chk("rst_hold_edge2", bus.zout, 1'b0);

        #2 rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, SEL_D2, 1'b1);
        tick();
        chk("first_edge_after_rst", bus.zout, 1'b1);

        drive(1'b0, 1'b0, 1'b0, 1'b1, SEL_D1, 1'b1);
        #1;
        chk("latency_pre_edge", bus.zout, 1'b1);
        tick();
        chk("d1_sel_d3_ignored", bus.zout, 1'b0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, SEL_D0, 1'b1);
        tick();
        chk("d0_sel", bus.zout, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, SEL_D3, 1'b1);
        tick();
        chk("switch_to_d3", bus.zout, 1'b0);

        drive(1'b1, 1'b1, 1'b0, 1'b0, SEL_D2, 1'b1);
        tick();
        chk("d2_sel", bus.zout, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, SEL_D0, 1'b0);
        tick();
        chk("en0_hold_a", bus.zout, 1'b0);
        tick();
        chk("en0_hold_b", bus.zout, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, SEL_D0, 1'b1);
        tick();
        chk("en1_reload", bus.zout, 1'b1);

        // Mid-operation reset with en held high, then release with en low: no replay.
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_async", bus.zout, 1'b0);
        tick();
        chk("rst_mid_en_ignored", bus.zout, 1'b0);
        #2 rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, SEL_D0, 1'b0);
        tick();
        chk("no_replay_after_rst", bus.zout, 1'b0);

        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < 16; p++) begin
                pat = 4'(p);
                drive(pat[0], pat[1], pat[2], pat[3], mux4_sel_t'(s), 1'b1);
                chk_comb("sweep_comb");
                tick();
                chk("sweep_reg", bus.zout, exp_z);
            end
        end

        for (int i = 0; i < 300; i++) begin
            drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                  mux4_sel_t'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
            rst = ($urandom_range(0, 15) == 0);
            if (rst) begin
                exp_z = '0;
                #1;
                chk("rnd_rst_async", bus.zout, 1'b0);
            end
            chk_comb("rnd_comb");
            tick();
            chk("rnd_reg", bus.zout, exp_z);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
